fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h100, the first fetch address after reset.
REQ-002 SHALL have parameter ADDR_WIDTH, default core::ADDR_WIDTH, the word-address width of the instruction memory.
REQ-003 SHALL have parameter DEPTH, default core::DEPTH, the instruction memory depth in words.
REQ-004 SHALL have parameter FQ_DEPTH, default 4, the fetch-queue entry count; power of two, at least 2.
REQ-005 SHALL have parameter INIT_FILE, default "", the memory hex image.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, on which all state changes at the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports wdata_i (input, core::DATA_WIDTH), wen_i (input, core::DATA_BYTES) and waddr_i (input, ADDR_WIDTH): the byte-enabled instruction-memory write port.
REQ-009 SHALL have ports redirect_i (input, 1) and redirect_pc_i (input, 32): a branch or jump target request.
REQ-010 SHALL have port instr_valid_o (output, 1): the queue head holds a valid instruction.
REQ-011 SHALL have port instr_ready_i (input, 1): the decode stage accepts the head entry.
REQ-012 SHALL have ports instr_o (output, 32) and pc_o (output, 32): the head instruction and its PC.

Function
REQ-013 SHALL hold a fetch PC (fpc), advancing by 4 per issued fetch; the only other way to change fpc is a redirect.
REQ-014 SHALL issue a fetch in a cycle only when (queue count + in-flight count) < FQ_DEPTH, wen_i == 0 and redirect_i == 0.
REQ-015 SHALL give memory writes priority over fetches (single port); a write cycle issues no fetch and leaves fpc unchanged.
REQ-016 SHALL have a memory read latency of 1 cycle: an address issued in cycle N returns data in cycle N+1, which is pushed with its PC into the queue at the end of N+1.
REQ-017 SHALL have a fetch-to-instr_valid_o latency of 2 cycles, with no bypass.
REQ-018 SHALL form the memory address as fpc[ADDR_WIDTH+1:2]; fpc bits beyond ADDR_WIDTH+2 wrap silently.
REQ-019 SHALL complete a handshake when instr_valid_o && instr_ready_i; the head pops at the clock edge.
REQ-020 SHALL hold instr_o and pc_o stable while instr_valid_o is high and instr_ready_i is low.
REQ-021 SHALL keep instr_o and pc_o driven from the head entry; they are don't-care when instr_valid_o is low.
REQ-022 SHALL allow a push and a pop in the same cycle, with count unchanged; this holds when full.
REQ-023 SHALL, on redirect_i, empty the queue, discard the in-flight read and set fpc to {redirect_pc_i[31:2], 2'b00}, all at that edge.
REQ-024 SHALL force instr_valid_o low in the cycle after a redirect and resume fetching from the new fpc.
REQ-025 SHALL, when redirect_i and a handshake coincide, let the redirect win; the pop is irrelevant because the queue is flushed.
REQ-026 SHALL wrap fpc modulo 2^32 (0xFFFFFFFC + 4 = 0).
REQ-027 SHALL never overflow the queue (guaranteed by REQ-014), and SHALL never pop when it is empty.

Reset
REQ-028 SHALL, while rst is high at an edge, set fpc = RESET_PC, queue count = 0, read and write pointers = 0 and in-flight = 0.
REQ-029 SHALL hold instr_valid_o = 0 during reset; instr_o and pc_o are 0 after reset.
REQ-030 SHALL discard any in-flight read when reset is asserted mid-operation; memory contents are not cleared.
REQ-031 SHALL issue the first fetch, at RESET_PC, in the first cycle with rst low.

Structure
REQ-032 SHALL keep RESET_PC default, FQ_DEPTH default and the fetch-queue entry typedef (struct of pc[31:0] and instr[31:0]) in package core.
REQ-033 SHALL reuse the existing synchronous single-port memory sub-module for storage.
REQ-034 SHALL use one new natural sub-module, fetch_queue: a parametrised synchronous FIFO with flush, push, pop, count, full and empty.
REQ-035 SHALL consist only of pointer, count and flag logic besides fpc, with no other FSM.

Verification
REQ-036 Reset release, RESET_PC=0x100, ready=1 SHALL give instr_valid_o high 2 cycles later with pc_o = 0x100, 0x104, 0x108 on consecutive cycles.
REQ-037 ready=0 for 10 cycles SHALL fill the queue (4 entries, pc 0x100–0x10C), stop fetch issue and hold head pc_o=0x100; ready=1 SHALL then drain in order.
REQ-038 A redirect to 0x203 while the queue is full SHALL drop instr_valid_o next cycle, then deliver pc_o = 0x200 with the memory word 0x80 two cycles later.
REQ-039 A redirect in the same cycle as a handshake SHALL produce no output of stale PCs after the redirect; the next delivered pc_o is the target.
REQ-040 A write of 0xDEADBEEF to word 0x41 during streaming SHALL stall fetch for 1 cycle, and a later fetch of pc 0x104 SHALL return 0xDEADBEEF.
REQ-041 Reset asserted with 1 fetch in flight and 3 entries queued SHALL give instr_valid_o = 0 next cycle and a restart at 0x100 with no stale entries.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the instruction-fetch slice.
// Contents: memory geometry, reset PC / fetch-queue depth defaults,
// the fetch-queue entry type and a PC alignment helper.
package core;
  localparam int ADDR_WIDTH = 10;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int DATA_WIDTH = 32;
  localparam int DATA_BYTES = DATA_WIDTH / 8;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          FQ_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // Instructions are word aligned; the low two bits of any target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush_i         - empty the queue at the next edge (wins over push/pop)
//   push_i, data_i  - enqueue an entry
//   pop_i           - dequeue the head entry
//   data_o          - head entry
//   count_o         - number of stored entries
//   full_o, empty_o - occupancy flags
module fetch_queue #(
  parameter  int DEPTH = core::FQ_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            push_i,
  input  core::fq_entry_t data_i,
  input  logic            pop_i,
  output core::fq_entry_t data_o,
  output logic [CW-1:0]   count_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int PW = $clog2(DEPTH);

  core::fq_entry_t entry_q [DEPTH];
  core::fq_entry_t entry_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  // Guards keep the storage consistent even if a caller misbehaves;
  // a push into a full queue is accepted only when the head leaves.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (do_push && !flush_i) begin
      entry_d[wptr_q] = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign data_o  = entry_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit_mem.sv
// Synchronous single-port instruction memory with byte-enabled writes.
// Ports:
//   clk     - clock
//   en_i    - access enable (read when we_i == 0, write otherwise)
//   we_i    - per-byte write enables
//   addr_i  - word address
//   wdata_i - write data
//   rdata_o - read data, valid the cycle after a read access
// INIT_FILE names the hex image the memory is built from in the target
// flow; contents are otherwise loaded through the write port.
module fetch_unit_mem #(
  parameter int ADDR_WIDTH = core::ADDR_WIDTH,
  parameter int DEPTH      = core::DEPTH,
  parameter     INIT_FILE  = ""
) (
  input  logic                        clk,
  input  logic                        en_i,
  input  logic [core::DATA_BYTES-1:0] we_i,
  input  logic [ADDR_WIDTH-1:0]       addr_i,
  input  logic [core::DATA_WIDTH-1:0] wdata_i,
  output logic [core::DATA_WIDTH-1:0] rdata_o
);
  logic [core::DATA_WIDTH-1:0] mem [DEPTH];
  logic [core::DATA_WIDTH-1:0] rdata_q;

  // Plain array with registered read so the tools map it onto block RAM.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < core::DATA_BYTES; b++) begin
        if (we_i[b]) begin
          mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
      if (we_i == '0) begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential fetch PC, single-port instruction
// memory shared with a byte-enabled write port, and a fetch queue feeding
// decode through a valid/ready handshake.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   wdata_i, wen_i, waddr_i  - instruction-memory write (priority over fetch)
//   redirect_i, redirect_pc_i- branch/jump target; flushes queue and read
//   instr_valid_o            - queue head valid
//   instr_ready_i            - decode accepts head
//   instr_o, pc_o            - head instruction and its PC
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = core::RESET_PC,
  parameter int          ADDR_WIDTH = core::ADDR_WIDTH,
  parameter int          DEPTH      = core::DEPTH,
  parameter int          FQ_DEPTH   = core::FQ_DEPTH,
  parameter              INIT_FILE  = ""
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [core::DATA_WIDTH-1:0] wdata_i,
  input  logic [core::DATA_BYTES-1:0] wen_i,
  input  logic [ADDR_WIDTH-1:0]       waddr_i,
  input  logic                        redirect_i,
  input  logic [31:0]                 redirect_pc_i,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i,
  output logic [31:0]                 instr_o,
  output logic [31:0]                 pc_o
);
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [31:0]     fpc_q, fpc_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            mem_write, issue;
  logic            fq_push, fq_pop, fq_full, fq_empty;
  logic [CW-1:0]   fq_count;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]     mem_rdata;
  core::fq_entry_t push_entry, head_entry;

  assign mem_write = |wen_i;

  // The in-flight read is counted as occupied space so the word it returns
  // always has a slot. Pops are not credited here; that costs at most one
  // bubble when the queue is full and keeps the issue path short.
  assign issue = !rst && !mem_write && !redirect_i && !fq_full &&
                 ((int'(fq_count) + int'(inflight_q)) < FQ_DEPTH);

  // Upper fpc bits above the memory span are ignored, so fetches alias.
  assign mem_addr = mem_write ? waddr_i : fpc_q[ADDR_WIDTH+1:2];

  always_comb begin
    fpc_d         = fpc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (redirect_i) begin
      fpc_d = core::align_pc(redirect_pc_i);
    end else if (issue) begin
      fpc_d         = fpc_q + 32'd4;
      inflight_pc_d = fpc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_unit_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_FILE  (INIT_FILE)
  ) u_mem (
    .clk     (clk),
    .en_i    (issue || mem_write),
    .we_i    (wen_i),
    .addr_i  (mem_addr),
    .wdata_i (wdata_i),
    .rdata_o (mem_rdata)
  );

  // A read landing in a redirect cycle belongs to the abandoned path.
  assign fq_push    = inflight_q && !redirect_i;
  assign fq_pop     = instr_valid_o && instr_ready_i;
  assign push_entry = '{pc: inflight_pc_q, instr: mem_rdata};

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (fq_push),
    .data_i  (push_entry),
    .pop_i   (fq_pop),
    .data_o  (head_entry),
    .count_o (fq_count),
    .full_o  (fq_full),
    .empty_o (fq_empty)
  );

  assign instr_valid_o = !fq_empty;
  assign instr_o       = head_entry.instr;
  assign pc_o          = head_entry.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_fetch_unit;
  localparam int AW = core::ADDR_WIDTH;
  localparam int NW = 1 << AW;
  localparam int QD = core::FQ_DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   wdata;
  logic [3:0]    wen;
  logic [AW-1:0] waddr;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          ready;
  logic          instr_valid_o;
  logic [31:0]   instr_o, pc_o;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h100), .FQ_DEPTH(QD)) dut (
    .clk           (clk),
    .rst           (rst),
    .wdata_i       (wdata),
    .wen_i         (wen),
    .waddr_i       (waddr),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (ready),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  // Reference: a fetch reads memory when issued, becomes pending, lands in
  // the delivery queue one cycle later and is visible the cycle after that.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  ent_t        mpend[$];
  logic [31:0] mmem [NW];
  logic [31:0] mfpc;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          check_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    ent_t e;
    bit   do_issue;
    if (rst) begin
      mq.delete();
      mpend.delete();
      mfpc = 32'h100;
    end else begin
      do_issue = ((mq.size() + mpend.size()) < QD) && (wen == 4'h0) && !redirect;
      if (redirect) begin
        mq.delete();
        mpend.delete();
        mfpc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (mq.size() > 0 && ready) void'(mq.pop_front());
        if (mpend.size() > 0) mq.push_back(mpend.pop_front());
        if (do_issue) begin
          e.pc    = mfpc;
          e.instr = mmem[mfpc[AW+1:2]];
          mpend.push_back(e);
          mfpc = mfpc + 32'd4;
        end
      end
    end
    for (int b = 0; b < 4; b++) begin
      if (wen[b]) mmem[waddr][b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check32("valid", 32'(instr_valid_o), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check32("pc", pc_o, mq[0].pc);
        check32("instr", instr_o, mq[0].instr);
        if (ready && !rst && !redirect)
          $display("xfer pc=%h instr=%h", pc_o, instr_o);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wen = 4'h0; waddr = '0; wdata = '0;
    redirect = 1'b0; redirect_pc = '0; ready = 1'b0;

    // Preload every word through the write port while in reset.
    for (int i = 0; i < NW; i++) begin
      waddr = AW'(i);
      wdata = 32'hC0DE_0000 | 32'(i);
      wen   = 4'hF;
      tick();
    end
    wen = 4'h0;
    tick(2);
    check_en = 1'b1;
    check32("rst_valid", 32'(instr_valid_o), 32'd0);
    check32("rst_pc", pc_o, 32'd0);
    check32("rst_instr", instr_o, 32'd0);

    // Streaming from reset.
    rst = 1'b0; ready = 1'b1;
    tick(2);
    check32("stream_valid", 32'(instr_valid_o), 32'd1);
    check32("stream_pc0", pc_o, 32'h100);
    check32("stream_instr0", instr_o, 32'hC0DE_0040);
    tick(); check32("stream_pc1", pc_o, 32'h104);
    tick(); check32("stream_pc2", pc_o, 32'h108);

    // Fill with decode stalled, then drain.
    rst = 1'b1; ready = 1'b0; tick(); rst = 1'b0;
    tick(10);
    check32("fill_valid", 32'(instr_valid_o), 32'd1);
    check32("fill_head", pc_o, 32'h100);
    ready = 1'b1;
    tick(); check32("drain_pc1", pc_o, 32'h104);
    tick(); check32("drain_pc2", pc_o, 32'h108);
    tick(); check32("drain_pc3", pc_o, 32'h10C);

    // Redirect while full.
    ready = 1'b0; tick(10);
    do_redirect(32'h203);
    check32("redir_drop", 32'(instr_valid_o), 32'd0);
    tick(); check32("redir_gap", 32'(instr_valid_o), 32'd0);
    tick();
    check32("redir_valid", 32'(instr_valid_o), 32'd1);
    check32("redir_pc", pc_o, 32'h200);
    check32("redir_instr", instr_o, 32'hC0DE_0080);

    // Redirect coinciding with a handshake.
    ready = 1'b1; tick(3);
    do_redirect(32'h300);
    check32("hs_redir_drop", 32'(instr_valid_o), 32'd0);
    tick(); check32("hs_redir_gap", 32'(instr_valid_o), 32'd0);
    tick(); check32("hs_redir_pc", pc_o, 32'h300);

    // Write during streaming, then refetch the written word.
    tick(2);
    waddr = AW'(32'h41); wdata = 32'hDEAD_BEEF; wen = 4'hF;
    tick(); wen = 4'h0;
    tick(3);
    do_redirect(32'h100);
    tick(2); check32("wr_pc0", pc_o, 32'h100);
    tick(); check32("wr_pc1", pc_o, 32'h104);
    check32("wr_instr1", instr_o, 32'hDEAD_BEEF);

    // Reset with 3 queued and 1 in flight.
    ready = 1'b0;
    do_redirect(32'h100);
    tick(4);
    check32("pre_rst_head", pc_o, 32'h100);
    rst = 1'b1; tick(); rst = 1'b0;
    check32("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    ready = 1'b1;
    tick(2);
    check32("restart_pc", pc_o, 32'h100);
    tick(); check32("restart_instr", instr_o, 32'hDEAD_BEEF);

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFF8);
    tick(2); check32("wrap_pc0", pc_o, 32'hFFFF_FFF8);
    tick(); check32("wrap_pc1", pc_o, 32'hFFFF_FFFC);
    tick(); check32("wrap_pc2", pc_o, 32'h0);
    check32("wrap_instr2", instr_o, 32'hC0DE_0000);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
      wen         = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0;
      waddr       = AW'($urandom);
      wdata       = $urandom;
      ready       = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b0; redirect = 1'b0; wen = 4'h0; ready = 1'b1;
    tick(4);
    check_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
